memshare_rqst_profiler: RTL and testbench
=========================================

# memshare_rqst_profiler

Arrival-requestor profiling stage for SCU.memShare, directly upstream of the L1PA regFile-mapping unit. Each cycle it accepts one share-group request pattern: a per-requestor enable and column-bank address for each of the SHARE_GROUP_SIZE requestors. For every pattern it computes the number of allocation sequences needed, checks the three memShare DRCs (two per pattern, one across a history of ARR_RQST_TRACK_DEPTH patterns), and hands the annotated pattern downstream over a valid/ready handshake.

## Interface
Parameters:
- SHARE_GROUP_SIZE, 5, number of requestors in a share group.
- RQST_ADDR_BITWIDTH, 2, column-bank address width per requestor. Bank count is 2**RQST_ADDR_BITWIDTH.
- SHARE_COL_CONFIG, 5'b10101, per-requestor shared-column flag (1 = shared).
- ARR_RQST_TRACK_DEPTH, 4, history depth for DRC3.
- MAX_ALLOC_SEQ_NUM, 2, maximum number of allocation sequences.
- MEMSHARE_DRC_NUM, 3, number of DRC result bits.

Ports:
- sys_clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- rqst_valid  in  1  input pattern valid.
- rqst_ready  out  1  input pattern accepted when rqst_valid && rqst_ready.
- rqst_en  in  SHARE_GROUP_SIZE  active-requestor mask.
- rqst_addr  in  SHARE_GROUP_SIZE*RQST_ADDR_BITWIDTH  bank addresses packed; requestor 0 in the LSBs.
- hist_clr  in  1  clears the DRC3 history.
- out_valid  out  1  annotated pattern valid.
- out_ready  in  1  downstream accept.
- out_en, out_addr  out  as inputs  pattern passed through unchanged.
- out_seq_num  out  $clog2(MAX_ALLOC_SEQ_NUM+1)  allocation sequences required.
- out_drc_fail  out  MEMSHARE_DRC_NUM  failure flags, one bit per DRC, indexed by memShare_drc_index.
- drc_fail_cnt  out  8  saturating count of emitted patterns with any DRC bit set.

## Operation
- Two-register pipeline:
  - S1 captures the input on acceptance.
  - S2 is the output register, loaded from S1 when it advances.
  - All evaluation is combinational on S1 contents.
- Inactive requestors (rqst_en bit 0) are ignored by every check.
- Bank-hit counts: hit[b] = number of active requestors with addr == b.
- Sequence count:
  - out_seq_num = min(max_b hit[b], MAX_ALLOC_SEQ_NUM).
  - It is 0 when no requestor is active.
- DRC1 (bit 0): set when any active non-shared requestor (SHARE_COL_CONFIG bit = 0) addresses a GP2 bank, i.e. address LSB = 1 (addresses 1 or 3).
- DRC2 (bit 1): set when any hit[b] > MAX_ALLOC_SEQ_NUM.
- DRC3 (bit 2):
  - History: hist is an ARR_RQST_TRACK_DEPTH-1 bit shift register holding the "needed 2 sequences" flag of the most recent patterns that advanced into S2.
  - DRC3 is set when the current pattern has out_seq_num == 2 and every hist bit is 1, i.e. ARR_RQST_TRACK_DEPTH consecutive 2-sequence patterns.
  - hist shifts in the current flag when S1 advances.
- hist_clr:
  - hist is zeroed.
  - A pattern advancing in the same cycle is evaluated against an all-zero history (DRC3 = 0), and its flag is not recorded.
- drc_fail_cnt increments by 1 when S1 advances with any DRC bit set, and saturates at 255.
- Failing patterns are still forwarded. This block never drops patterns.

## Timing
- Reset: all of the following clear to 0.
  - S1 valid, out_valid, out_en, out_addr, out_seq_num, out_drc_fail.
  - hist, drc_fail_cnt.
  - After reset, rqst_ready = 1.
- Handshake signals:
  - s1_adv = s1_valid && (!out_valid || out_ready).
  - rqst_ready = !s1_valid || s1_adv. This is combinational; there is no path from rqst_valid to rqst_ready.
- Latency: a pattern accepted at edge N appears on out_valid after edge N+1 (two registers). There are no bubbles under full throughput, so the block sustains one pattern per cycle.
- Backpressure:
  - While out_valid && !out_ready, all out_* signals hold stable.
  - At most two patterns are in flight (S1 and S2).
- Reset asserted mid-operation discards both in-flight patterns and the history. No partial output is produced.

## Structure
- memShare_config_pkg gains:
  - typedef logic [MEMSHARE_DRC_NUM-1:0] memshare_drc_vec_t.
  - localparam MEMSHARE_BANK_NUM = 2**RQST_ADDR_BITWIDTH.
  - localparam DRC_FAIL_CNT_WIDTH = 8.
- DRC bit positions use the existing memShare_drc_index enum.
- One sub-module: memshare_bank_hit_cnt.
  - Purely combinational.
  - Inputs: en and addr.
  - Outputs: per-bank hit counts and max hit.
  - Reused by the downstream allocator.

## Test plan
- Distinct banks: en=5'b01111, addr r0..r3 = 1,0,3,2, accepted at edge N. Expected at N+2: out_seq_num=1, out_drc_fail=3'b000.
- One shared bank: en=5'b11111, addr r0..r4 = 1,0,1,2,3. Expected: out_seq_num=2, out_drc_fail=000.
- DRC1 and DRC2:
  - en=5'b00010, r1 addr=3. Expected: drc=001, seq=1.
  - en=5'b00111, r0..r2 all = 0. Expected: drc=010, seq=2.
  - drc_fail_cnt reads 2 after both.
- DRC3:
  - Four back-to-back 2-sequence patterns: the 4th has drc=100 and the first three have 000.
  - Repeat with hist_clr pulsed alongside the 3rd pattern: the 4th has drc=000.
- Backpressure: out_ready=0 for 5 cycles while rqst_valid=1 continuously.
  - Exactly 2 patterns are accepted and rqst_ready=0 thereafter.
  - out_* stays stable.
  - Raising out_ready drains the patterns in order, one per cycle.
- Reset mid-flight: rst with 2 patterns held.
  - The next cycle shows out_valid=0, drc_fail_cnt=0, rqst_ready=1.
  - A subsequent 2-sequence pattern gets DRC3=0.

Source files
------------

// File: rtl/memShare_config_pkg.sv
// Shared memShare configuration: share-group geometry, DRC indexing and
// the helper types used by the profiling and allocation stages.
package memShare_config_pkg;

  localparam int SHARE_GROUP_SIZE     = 5;
  localparam int RQST_ADDR_BITWIDTH   = 2;
  localparam logic [SHARE_GROUP_SIZE-1:0] SHARE_COL_CONFIG = 5'b10101;
  localparam int ARR_RQST_TRACK_DEPTH = 4;
  localparam int MAX_ALLOC_SEQ_NUM    = 2;
  localparam int MEMSHARE_DRC_NUM     = 3;

  localparam int MEMSHARE_BANK_NUM  = 2 ** RQST_ADDR_BITWIDTH;
  localparam int DRC_FAIL_CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    DRC_GP2_NONSHARED = 2'd0,
    DRC_BANK_OVERFLOW = 2'd1,
    DRC_SEQ_HISTORY   = 2'd2
  } memShare_drc_index;

  typedef logic [MEMSHARE_DRC_NUM-1:0] memshare_drc_vec_t;

endpackage

// File: rtl/memshare_bank_hit_cnt.sv
// Per-bank count of active requestors and the largest such count; purely
// combinational so the downstream allocator can reuse it unchanged.
module memshare_bank_hit_cnt
  import memShare_config_pkg::*;
#(
  parameter int SHARE_GROUP_SIZE   = memShare_config_pkg::SHARE_GROUP_SIZE,
  parameter int RQST_ADDR_BITWIDTH = memShare_config_pkg::RQST_ADDR_BITWIDTH,
  localparam int BANK_NUM = 2 ** RQST_ADDR_BITWIDTH,
  localparam int CNT_W    = $clog2(SHARE_GROUP_SIZE + 1)
) (
  input  logic [SHARE_GROUP_SIZE-1:0]                    en,
  input  logic [SHARE_GROUP_SIZE*RQST_ADDR_BITWIDTH-1:0] addr,
  output logic [BANK_NUM*CNT_W-1:0]                      hit_cnt,
  output logic [CNT_W-1:0]                               max_hit
);

  logic [CNT_W-1:0] hit_s [BANK_NUM];

  // Count matching active requestors per bank.
  always_comb begin
    for (int b = 0; b < BANK_NUM; b++) begin
      hit_s[b] = '0;
      for (int r = 0; r < SHARE_GROUP_SIZE; r++) begin
        hit_s[b] = hit_s[b] + CNT_W'(en[r] &&
                   (addr[r*RQST_ADDR_BITWIDTH +: RQST_ADDR_BITWIDTH] == RQST_ADDR_BITWIDTH'(b)));
      end
    end
  end

  // Pack the counts and reduce to the maximum.
  always_comb begin
    hit_cnt = '0;
    max_hit = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      hit_cnt[b*CNT_W +: CNT_W] = hit_s[b];
      max_hit = (hit_s[b] > max_hit) ? hit_s[b] : max_hit;
    end
  end

endmodule

// File: rtl/memshare_rqst_profiler.sv
// Two-register profiling stage: annotates each share-group request pattern
// with its allocation sequence count and memShare DRC flags.
module memshare_rqst_profiler
  import memShare_config_pkg::*;
#(
  parameter int SHARE_GROUP_SIZE     = memShare_config_pkg::SHARE_GROUP_SIZE,
  parameter int RQST_ADDR_BITWIDTH   = memShare_config_pkg::RQST_ADDR_BITWIDTH,
  parameter logic [SHARE_GROUP_SIZE-1:0] SHARE_COL_CONFIG = memShare_config_pkg::SHARE_COL_CONFIG,
  parameter int ARR_RQST_TRACK_DEPTH = memShare_config_pkg::ARR_RQST_TRACK_DEPTH,
  parameter int MAX_ALLOC_SEQ_NUM    = memShare_config_pkg::MAX_ALLOC_SEQ_NUM,
  parameter int MEMSHARE_DRC_NUM     = memShare_config_pkg::MEMSHARE_DRC_NUM,
  localparam int AW    = SHARE_GROUP_SIZE * RQST_ADDR_BITWIDTH,
  localparam int SEQ_W = $clog2(MAX_ALLOC_SEQ_NUM + 1)
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic                          rqst_valid,
  output logic                          rqst_ready,
  input  logic [SHARE_GROUP_SIZE-1:0]   rqst_en,
  input  logic [AW-1:0]                 rqst_addr,
  input  logic                          hist_clr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SHARE_GROUP_SIZE-1:0]   out_en,
  output logic [AW-1:0]                 out_addr,
  output logic [SEQ_W-1:0]              out_seq_num,
  output logic [MEMSHARE_DRC_NUM-1:0]   out_drc_fail,
  output logic [DRC_FAIL_CNT_WIDTH-1:0] drc_fail_cnt
);

  localparam int BANK_NUM = 2 ** RQST_ADDR_BITWIDTH;
  localparam int HIT_W    = $clog2(SHARE_GROUP_SIZE + 1);
  localparam int HIST_W   = ARR_RQST_TRACK_DEPTH - 1;

  logic                        s1_valid_r;
  logic [SHARE_GROUP_SIZE-1:0] s1_en_r;
  logic [AW-1:0]               s1_addr_r;
  logic [HIST_W-1:0]           hist_r;

  logic                        s1_adv_s;
  logic [BANK_NUM*HIT_W-1:0]   hit_cnt_s;
  logic [HIT_W-1:0]            max_hit_s;
  logic [SEQ_W-1:0]            seq_num_s;
  logic                        need2_s;
  memshare_drc_vec_t           drc_s;

  assign s1_adv_s   = s1_valid_r && (!out_valid || out_ready);
  assign rqst_ready = !s1_valid_r || s1_adv_s;

  memshare_bank_hit_cnt #(
    .SHARE_GROUP_SIZE   (SHARE_GROUP_SIZE),
    .RQST_ADDR_BITWIDTH (RQST_ADDR_BITWIDTH)
  ) u_bank_hit_cnt (
    .en      (s1_en_r),
    .addr    (s1_addr_r),
    .hit_cnt (hit_cnt_s),
    .max_hit (max_hit_s)
  );

  assign seq_num_s = (max_hit_s > HIT_W'(MAX_ALLOC_SEQ_NUM)) ? SEQ_W'(MAX_ALLOC_SEQ_NUM)
                                                             : SEQ_W'(max_hit_s);
  assign need2_s   = (seq_num_s == SEQ_W'(2));

  // DRC evaluation on S1; a same-cycle history clear masks the history check.
  always_comb begin
    drc_s = '0;
    for (int r = 0; r < SHARE_GROUP_SIZE; r++) begin
      drc_s[DRC_GP2_NONSHARED] = drc_s[DRC_GP2_NONSHARED] |
        (s1_en_r[r] & ~SHARE_COL_CONFIG[r] & s1_addr_r[r*RQST_ADDR_BITWIDTH]);
    end
    for (int b = 0; b < BANK_NUM; b++) begin
      drc_s[DRC_BANK_OVERFLOW] = drc_s[DRC_BANK_OVERFLOW] |
        (hit_cnt_s[b*HIT_W +: HIT_W] > HIT_W'(MAX_ALLOC_SEQ_NUM));
    end
    drc_s[DRC_SEQ_HISTORY] = need2_s && (&hist_r) && !hist_clr;
  end

  // Input register S1.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_en_r    <= '0;
      s1_addr_r  <= '0;
    end else if (rqst_valid && rqst_ready) begin
      s1_valid_r <= 1'b1;
      s1_en_r    <= rqst_en;
      s1_addr_r  <= rqst_addr;
    end else if (s1_adv_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Output register S2; held while downstream stalls.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_en       <= '0;
      out_addr     <= '0;
      out_seq_num  <= '0;
      out_drc_fail <= '0;
    end else if (s1_adv_s) begin
      out_valid    <= 1'b1;
      out_en       <= s1_en_r;
      out_addr     <= s1_addr_r;
      out_seq_num  <= seq_num_s;
      out_drc_fail <= drc_s;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

  // Two-sequence history; a clear discards the flag of a same-cycle advance.
  always_ff @(posedge sys_clk) begin
    if (rst || hist_clr) begin
      hist_r <= '0;
    end else if (s1_adv_s) begin
      hist_r <= (hist_r << 1) | HIST_W'(need2_s);
    end
  end

  // Saturating count of forwarded patterns with any DRC failure.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      drc_fail_cnt <= '0;
    end else if (s1_adv_s && (|drc_s) && (drc_fail_cnt != {DRC_FAIL_CNT_WIDTH{1'b1}})) begin
      drc_fail_cnt <= drc_fail_cnt + DRC_FAIL_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_memshare_rqst_profiler.sv
// Directed, table-driven bench for memshare_rqst_profiler with hand-written
// sequences for history, backpressure and mid-flight reset.
module tb_memshare_rqst_profiler;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       rqst_valid = 1'b0;
  logic       rqst_ready;
  logic [4:0] rqst_en = 5'b0;
  logic [9:0] rqst_addr = 10'b0;
  logic       hist_clr = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [4:0] out_en;
  logic [9:0] out_addr;
  logic [1:0] out_seq_num;
  logic [2:0] out_drc_fail;
  logic [7:0] drc_fail_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 sys_clk = ~sys_clk;

  memshare_rqst_profiler dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .rqst_valid   (rqst_valid),
    .rqst_ready   (rqst_ready),
    .rqst_en      (rqst_en),
    .rqst_addr    (rqst_addr),
    .hist_clr     (hist_clr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_en       (out_en),
    .out_addr     (out_addr),
    .out_seq_num  (out_seq_num),
    .out_drc_fail (out_drc_fail),
    .drc_fail_cnt (drc_fail_cnt)
  );

  typedef struct {
    logic [4:0] en;
    logic [9:0] addr;
    logic [1:0] seq;
    logic [2:0] drc;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Four back-to-back two-sequence patterns; optional history clear with the 3rd.
  task automatic run_drc3(input logic clr_on3, input logic [2:0] exp4);
    logic [2:0] got [$];
    got.delete();
    for (int c = 0; c < 8; c++) begin
      rqst_valid = (c < 4);
      rqst_en    = 5'b00011;
      rqst_addr  = 10'd0;
      hist_clr   = clr_on3 && (c == 2);
      step();
      if (out_valid) got.push_back(out_drc_fail);
    end
    hist_clr = 1'b0;
    chk("drc3_count", got.size(), 4);
    if (got.size() == 4) begin
      chk("drc3_p1", got[0], 3'b000);
      chk("drc3_p2", got[1], 3'b000);
      chk("drc3_p3", got[2], 3'b000);
      chk("drc3_p4", got[3], exp4);
    end
  endtask

  initial begin
    int exp_cnt;
    int acc;
    int idx;
    logic acc_now;

    vecs[0] = '{5'b01111, 10'b00_10_11_00_01, 2'd1, 3'b000};
    vecs[1] = '{5'b11111, 10'b11_10_01_00_01, 2'd2, 3'b000};
    vecs[2] = '{5'b00010, 10'b00_00_00_11_00, 2'd1, 3'b001};
    vecs[3] = '{5'b00111, 10'b00_00_00_00_00, 2'd2, 3'b010};
    vecs[4] = '{5'b00000, 10'b11_11_11_11_11, 2'd0, 3'b000};
    vecs[5] = '{5'b11111, 10'b00_00_00_00_00, 2'd2, 3'b010};
    vecs[6] = '{5'b01000, 10'b00_01_00_00_00, 2'd1, 3'b001};
    vecs[7] = '{5'b10101, 10'b11_11_11_11_11, 2'd2, 3'b010};

    step();
    step();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_seq", out_seq_num, 2'd0);
    chk("rst_out_drc", out_drc_fail, 3'b000);
    chk("rst_out_en", out_en, 5'b0);
    chk("rst_cnt", drc_fail_cnt, 8'd0);
    chk("rst_ready", rqst_ready, 1'b1);

    exp_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      rqst_en    = vecs[i].en;
      rqst_addr  = vecs[i].addr;
      rqst_valid = 1'b1;
      chk($sformatf("v%0d_ready", i), rqst_ready, 1'b1);
      step();
      rqst_valid = 1'b0;
      chk($sformatf("v%0d_lat1", i), out_valid, 1'b0);
      step();
      chk($sformatf("v%0d_valid", i), out_valid, 1'b1);
      chk($sformatf("v%0d_seq", i), out_seq_num, vecs[i].seq);
      chk($sformatf("v%0d_drc", i), out_drc_fail, vecs[i].drc);
      chk($sformatf("v%0d_en", i), out_en, vecs[i].en);
      chk($sformatf("v%0d_addr", i), out_addr, vecs[i].addr);
      if (vecs[i].drc != 3'b000) exp_cnt++;
      if (i == 3) chk("cnt_after_drc12", drc_fail_cnt, 8'd2);
      step();
    end
    chk("cnt_after_vecs", drc_fail_cnt, exp_cnt);

    hist_clr = 1'b1;
    step();
    hist_clr = 1'b0;
    run_drc3(1'b0, 3'b100);
    exp_cnt++;
    hist_clr = 1'b1;
    step();
    hist_clr = 1'b0;
    run_drc3(1'b1, 3'b000);
    chk("cnt_after_drc3", drc_fail_cnt, exp_cnt);

    // Backpressure: stall downstream with a continuous request stream.
    out_ready  = 1'b0;
    acc        = 0;
    idx        = 0;
    rqst_en    = 5'b00001;
    rqst_addr  = 10'd1;
    rqst_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      acc_now = rqst_ready;
      step();
      if (acc_now) begin
        acc++;
        idx++;
        rqst_addr = 10'(idx + 1);
      end
      if (c >= 1) begin
        chk($sformatf("bp_hold_valid_c%0d", c), out_valid, 1'b1);
        chk($sformatf("bp_hold_addr_c%0d", c), out_addr, 10'd1);
        chk($sformatf("bp_hold_seq_c%0d", c), out_seq_num, 2'd1);
      end
    end
    chk("bp_accepted", acc, 2);
    chk("bp_ready_low", rqst_ready, 1'b0);
    rqst_valid = 1'b0;
    out_ready  = 1'b1;
    step();
    chk("bp_drain_valid", out_valid, 1'b1);
    chk("bp_drain_addr", out_addr, 10'd2);
    step();
    chk("bp_drain_empty", out_valid, 1'b0);

    // Fill history with three two-sequence patterns, then hold two and reset.
    rqst_en   = 5'b00011;
    rqst_addr = 10'd0;
    for (int c = 0; c < 5; c++) begin
      rqst_valid = (c < 3);
      step();
    end
    out_ready  = 1'b0;
    rqst_valid = 1'b1;
    step();
    step();
    rqst_valid = 1'b0;
    chk("rst_mid_full", rqst_ready, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_cnt", drc_fail_cnt, 8'd0);
    chk("rst_mid_ready", rqst_ready, 1'b1);
    out_ready  = 1'b1;
    rqst_valid = 1'b1;
    step();
    rqst_valid = 1'b0;
    step();
    chk("post_rst_valid", out_valid, 1'b1);
    chk("post_rst_seq", out_seq_num, 2'd2);
    chk("post_rst_drc", out_drc_fail, 3'b000);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
